// File: rtl/ppu_regs.sv
// CPU-facing PPU register file ($2000-$3FFF): ctrl/mask/status/scroll/addr/data ports
// plus a two-state VRAM access sequencer that stalls the CPU via open-drain rdy.
module ppu_regs (
    input  logic        clk_i,
    input  logic        n_reset_i,
    input  logic [15:0] addr_i,
    inout  wire  [7:0]  data_io,
    input  logic        we_i,
    inout  wire         rdy_io,
    output logic        nmi_o,
    input  logic        vblank_set_i,
    input  logic        vblank_clr_i,
    input  logic        spr0_hit_i,
    input  logic        spr_ovf_i,
    output logic [13:0] vaddr_o,
    output logic [7:0]  vdout_o,
    input  logic [7:0]  vdin_i,
    output logic        vreq_o,
    output logic        vwe_o,
    input  logic        vack_i,
    output logic [7:0]  ctrl_o,
    output logic [7:0]  mask_o,
    output logic [7:0]  scroll_x_o,
    output logic [7:0]  scroll_y_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  sx_q, sx_d;
    logic [7:0]  sy_q, sy_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  vdout_q, vdout_d;
    logic [13:0] t_q, t_d;
    logic [13:0] v_q, v_d;
    logic        w_q, w_d;
    logic        vblank_q, vblank_d;
    logic        dir_q, dir_d;

    logic        sel, busy, access, rd_status;
    logic [2:0]  idx;
    logic [7:0]  rd_val;
    logic        unused_addr;

    assign sel         = (addr_i[15:13] == 3'b001);
    assign idx         = addr_i[2:0];
    assign busy        = (state_q == StBusy);
    // Accesses that land while we hold rdy low are dropped, not queued.
    assign access      = sel & ~busy;
    assign rd_status   = access & ~we_i & (idx == 3'd2);
    assign unused_addr = ^addr_i[12:3];

    always_comb begin
        rd_val = 8'h00;
        unique case (idx)
            3'd2:    rd_val = {vblank_q, spr0_hit_i, spr_ovf_i, 5'b0};
            3'd7:    rd_val = rbuf_q;
            default: rd_val = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        mask_d   = mask_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        rbuf_d   = rbuf_q;
        vdout_d  = vdout_q;
        t_d      = t_q;
        v_d      = v_q;
        w_d      = w_q;
        vblank_d = vblank_q;
        dir_d    = dir_q;

        if (access && we_i) begin
            case (idx)
                3'd0: ctrl_d = data_io;
                3'd1: mask_d = data_io;
                3'd5: begin
                    if (!w_q) sx_d = data_io;
                    else      sy_d = data_io;
                    w_d = ~w_q;
                end
                3'd6: begin
                    if (!w_q) begin
                        t_d[13:8] = data_io[5:0];
                    end else begin
                        t_d[7:0] = data_io;
                        v_d      = {t_q[13:8], data_io};
                    end
                    w_d = ~w_q;
                end
                default: ;
            endcase
        end

        if (access && idx == 3'd7) begin
            state_d = StBusy;
            dir_d   = we_i;
            if (we_i) vdout_d = data_io;
        end

        if (busy && vack_i) begin
            state_d = StIdle;
            if (!dir_q) rbuf_d = vdin_i;
            v_d = v_q + (ctrl_q[2] ? 14'd32 : 14'd1);
        end

        // Priority: status read clears, a coincident set still lands, clr beats set.
        if (rd_status) begin
            vblank_d = 1'b0;
            w_d      = 1'b0;
        end
        if (vblank_set_i) vblank_d = 1'b1;
        if (vblank_clr_i) vblank_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q  <= StIdle;
            ctrl_q   <= 8'h00;
            mask_q   <= 8'h00;
            sx_q     <= 8'h00;
            sy_q     <= 8'h00;
            rbuf_q   <= 8'h00;
            vdout_q  <= 8'h00;
            t_q      <= 14'h0000;
            v_q      <= 14'h0000;
            w_q      <= 1'b0;
            vblank_q <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            rbuf_q   <= rbuf_d;
            vdout_q  <= vdout_d;
            t_q      <= t_d;
            v_q      <= v_d;
            w_q      <= w_d;
            vblank_q <= vblank_d;
            dir_q    <= dir_d;
        end
    end

    assign data_io    = (access && !we_i) ? rd_val : 8'hzz;
    assign rdy_io     = busy ? 1'b0 : 1'bz;
    assign nmi_o      = ctrl_q[7] & vblank_q;
    assign vaddr_o    = v_q;
    assign vdout_o    = vdout_q;
    assign vreq_o     = busy;
    assign vwe_o      = busy & dir_q;
    assign ctrl_o     = ctrl_q;
    assign mask_o     = mask_q;
    assign scroll_x_o = sx_q;
    assign scroll_y_o = sy_q;

endmodule

// File: tb/tb_ppu_regs.sv
// Self-checking bench for ppu_regs: register table, VRAM transfers, vblank/NMI, reset abort.
module tb_ppu_regs;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] addr;
    logic        we, tb_drv;
    logic [7:0]  tb_data;
    wire  [7:0]  data;
    wire         rdy;
    logic        nmi, vblank_set, vblank_clr, spr0_hit, spr_ovf;
    logic [13:0] vaddr;
    logic [7:0]  vdout, vdin;
    logic        vreq, vwe, vack;
    logic [7:0]  ctrl, mask, scroll_x, scroll_y;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    pullup (rdy);
    assign data = tb_drv ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    ppu_regs dut (
        .clk_i        (clk),
        .n_reset_i    (n_reset),
        .addr_i       (addr),
        .data_io      (data),
        .we_i         (we),
        .rdy_io       (rdy),
        .nmi_o        (nmi),
        .vblank_set_i (vblank_set),
        .vblank_clr_i (vblank_clr),
        .spr0_hit_i   (spr0_hit),
        .spr_ovf_i    (spr_ovf),
        .vaddr_o      (vaddr),
        .vdout_o      (vdout),
        .vdin_i       (vdin),
        .vreq_o       (vreq),
        .vwe_o        (vwe),
        .vack_i       (vack),
        .ctrl_o       (ctrl),
        .mask_o       (mask),
        .scroll_x_o   (scroll_x),
        .scroll_y_o   (scroll_y)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        addr = 16'h0000; we = 1'b0; tb_drv = 1'b0; tb_data = 8'h00;
        vblank_set = 1'b0; vblank_clr = 1'b0; vack = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; tb_drv = 1'b1; tb_data = d;
        @(posedge clk); #1;
        idle_bus();
    endtask

    // Expected byte is queued on drive and popped when the DUT presents it.
    task automatic bus_rd(input string name, input logic [15:0] a, input logic [7:0] e,
                          input logic vset);
        @(negedge clk);
        addr = a; we = 1'b0; tb_drv = 1'b0; vblank_set = vset;
        exp_q.push_back(e);
        #1;
        chk(name, {24'h0, data}, {24'h0, exp_q.pop_front()});
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic cyc(input logic vset, input logic vclr, input logic ack, input logic [7:0] vd);
        @(negedge clk);
        vblank_set = vset; vblank_clr = vclr; vack = ack; vdin = vd;
        @(posedge clk); #1;
        idle_bus();
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [1:0]  st;
        logic [7:0]  rd;
        logic [7:0]  m;
        logic [7:0]  sx;
        logic [7:0]  sy;
    } vec_t;

    vec_t vecs[14];
    int   low_cnt;

    initial begin
        vecs[0]  = '{1'b1, 16'h2001, 8'h1E, 2'b00, 8'h00, 8'h1E, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 16'h2005, 8'h12, 2'b00, 8'h00, 8'h1E, 8'h12, 8'h00};
        vecs[2]  = '{1'b1, 16'h2005, 8'h34, 2'b00, 8'h00, 8'h1E, 8'h12, 8'h34};
        vecs[3]  = '{1'b1, 16'h200D, 8'h56, 2'b00, 8'h00, 8'h1E, 8'h56, 8'h34};
        vecs[4]  = '{1'b0, 16'h2002, 8'h00, 2'b00, 8'h00, 8'h1E, 8'h56, 8'h34};
        vecs[5]  = '{1'b1, 16'h3FF5, 8'h78, 2'b00, 8'h00, 8'h1E, 8'h78, 8'h34};
        vecs[6]  = '{1'b1, 16'h2003, 8'hFF, 2'b00, 8'h00, 8'h1E, 8'h78, 8'h34};
        vecs[7]  = '{1'b1, 16'h2015, 8'h9A, 2'b00, 8'h00, 8'h1E, 8'h78, 8'h9A};
        vecs[8]  = '{1'b0, 16'h2002, 8'h00, 2'b11, 8'h60, 8'h1E, 8'h78, 8'h9A};
        vecs[9]  = '{1'b0, 16'h2000, 8'h00, 2'b11, 8'h00, 8'h1E, 8'h78, 8'h9A};
        vecs[10] = '{1'b0, 16'h2004, 8'h00, 2'b01, 8'h00, 8'h1E, 8'h78, 8'h9A};
        vecs[11] = '{1'b1, 16'h2009, 8'h3C, 2'b00, 8'h00, 8'h3C, 8'h78, 8'h9A};
        vecs[12] = '{1'b1, 16'h4005, 8'hEE, 2'b00, 8'h00, 8'h3C, 8'h78, 8'h9A};
        vecs[13] = '{1'b1, 16'h0005, 8'hEE, 2'b00, 8'h00, 8'h3C, 8'h78, 8'h9A};

        idle_bus();
        n_reset = 1'b0; vdin = 8'h00; spr0_hit = 1'b0; spr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {24'h0, ctrl}, 32'h0);
        chk("rst_mask", {24'h0, mask}, 32'h0);
        chk("rst_sx", {24'h0, scroll_x}, 32'h0);
        chk("rst_sy", {24'h0, scroll_y}, 32'h0);
        chk("rst_vaddr", {18'h0, vaddr}, 32'h0);
        chk("rst_vreq", {31'h0, vreq}, 32'h0);
        chk("rst_vwe", {31'h0, vwe}, 32'h0);
        chk("rst_nmi", {31'h0, nmi}, 32'h0);
        chk("rst_rdy", {31'h0, rdy}, 32'h1);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            spr0_hit = vecs[i].st[1];
            spr_ovf  = vecs[i].st[0];
            if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].wd);
            else            bus_rd($sformatf("vec%0d_rd", i), vecs[i].a, vecs[i].rd, 1'b0);
            chk($sformatf("vec%0d_mask", i), {24'h0, mask}, {24'h0, vecs[i].m});
            chk($sformatf("vec%0d_sx", i), {24'h0, scroll_x}, {24'h0, vecs[i].sx});
            chk($sformatf("vec%0d_sy", i), {24'h0, scroll_y}, {24'h0, vecs[i].sy});
        end
        spr0_hit = 1'b0; spr_ovf = 1'b0;

        // VRAM write with a 3-cycle stall; a mask write during the stall must be dropped.
        bus_wr(16'h2006, 8'h21);
        bus_wr(16'h2006, 8'h08);
        chk("w_vaddr_set", {18'h0, vaddr}, 32'h2108);
        bus_wr(16'h2007, 8'h5A);
        chk("w_vreq", {31'h0, vreq}, 32'h1);
        chk("w_vwe", {31'h0, vwe}, 32'h1);
        chk("w_vdout", {24'h0, vdout}, 32'h5A);
        low_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                addr = 16'h2001; we = 1'b1; tb_drv = 1'b1; tb_data = 8'hFF;
            end
            if (k == 2) vack = 1'b1;
            #1;
            if (rdy === 1'b0) low_cnt++;
            @(posedge clk); #1;
            idle_bus();
        end
        chk("w_rdy_low_cycles", low_cnt, 3);
        chk("w_rdy_release", {31'h0, rdy}, 32'h1);
        chk("w_vreq_drop", {31'h0, vreq}, 32'h0);
        chk("w_vaddr_inc", {18'h0, vaddr}, 32'h2109);
        chk("w_stall_ignored", {24'h0, mask}, 32'h3C);

        // Buffered reads with +32 increment.
        bus_wr(16'h2000, 8'h04);
        bus_wr(16'h2006, 8'h20);
        bus_wr(16'h2006, 8'h00);
        bus_rd("r_first", 16'h2007, 8'h00, 1'b0);
        chk("r_vwe_low", {31'h0, vwe}, 32'h0);
        chk("r_vreq", {31'h0, vreq}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h11);
        chk("r_vaddr_2020", {18'h0, vaddr}, 32'h2020);
        bus_rd("r_second", 16'h2007, 8'h11, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h22);
        chk("r_vaddr_2040", {18'h0, vaddr}, 32'h2040);
        bus_rd("r_third", 16'h2007, 8'h22, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h33);

        // 14-bit wrap of v.
        bus_wr(16'h2000, 8'h00);
        bus_wr(16'h2006, 8'h3F);
        bus_wr(16'h2006, 8'hFF);
        bus_wr(16'h2007, 8'h01);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_vaddr", {18'h0, vaddr}, 32'h0);

        // Status read resets the shared toggle.
        bus_wr(16'h2006, 8'h3F);
        bus_rd("toggle_rd", 16'h2002, 8'h00, 1'b0);
        bus_wr(16'h2006, 8'h10);
        bus_wr(16'h2006, 8'h00);
        chk("toggle_vaddr", {18'h0, vaddr}, 32'h1000);

        // NMI from vblank and from a late ctrl[7] write.
        bus_wr(16'h2000, 8'h80);
        chk("nmi_pre", {31'h0, nmi}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("nmi_set", {31'h0, nmi}, 32'h1);
        spr0_hit = 1'b1;
        bus_rd("mirror_status", 16'h3FFA, 8'hC0, 1'b0);
        spr0_hit = 1'b0;
        chk("nmi_after_rd", {31'h0, nmi}, 32'h0);
        bus_wr(16'h2000, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("nmi_masked", {31'h0, nmi}, 32'h0);
        bus_wr(16'h2000, 8'h80);
        chk("nmi_late_ctrl", {31'h0, nmi}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("nmi_clr", {31'h0, nmi}, 32'h0);

        // Set racing a status read; set and clr together.
        bus_rd("race_rd", 16'h2002, 8'h00, 1'b1);
        chk("race_nmi", {31'h0, nmi}, 32'h1);
        bus_rd("race_after", 16'h2002, 8'h80, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        bus_rd("setclr_rd", 16'h2002, 8'h00, 1'b0);

        // Reset during BUSY aborts; a late vack is ignored.
        bus_wr(16'h2001, 8'hAA);
        bus_wr(16'h2005, 8'h44);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        bus_wr(16'h2007, 8'h77);
        chk("abort_busy", {31'h0, vreq}, 32'h1);
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("abort_vreq", {31'h0, vreq}, 32'h0);
        chk("abort_rdy", {31'h0, rdy}, 32'h1);
        chk("abort_ctrl", {24'h0, ctrl}, 32'h0);
        chk("abort_mask", {24'h0, mask}, 32'h0);
        chk("abort_sx", {24'h0, scroll_x}, 32'h0);
        chk("abort_vaddr", {18'h0, vaddr}, 32'h0);
        chk("abort_nmi", {31'h0, nmi}, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 8'h99);
        chk("late_vack_vaddr", {18'h0, vaddr}, 32'h0);
        chk("late_vack_vreq", {31'h0, vreq}, 32'h0);
        bus_rd("late_vack_buf", 16'h2007, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppu_regs.md
PPU_REGS -- requirements
Module: ppu_regs

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 n_reset  input  1  reset, asynchronous, active-low.
REQ-003 addr  input  16  CPU bus address.
REQ-004 data  inout  8  CPU data bus; driven only during a selected read, otherwise high-Z.
REQ-005 we  input  1  CPU write strobe; 1=write, 0=read.
REQ-006 rdy  inout  1  bus ready, open-drain; driven 0 while stalling, otherwise high-Z.
REQ-007 nmi  output  1  level NMI request to CPU, active-high.
REQ-008 vblank_set, vblank_clr  input  1 each  one-cycle pulses from the PPU timing block.
REQ-009 spr0_hit, spr_ovf  input  1 each  status levels from the sprite unit.
REQ-010 vaddr  output  14  VRAM address.
REQ-011 vdout  output  8  VRAM write data.
REQ-012 vdin  input  8  VRAM read data, valid when vack=1.
REQ-013 vreq, vwe  output  1 each  VRAM request and direction (1=write).
REQ-014 vack  input  1  VRAM completion, one-cycle pulse.
REQ-015 ctrl, mask  output  8 each  current $2000/$2001 values.
REQ-016 scroll_x, scroll_y  output  8 each  latched $2005 values.

Function
REQ-017 Select = addr[15:13]==3'b001; register index = addr[2:0]; $2000-$3FFF mirrors every 8 bytes.
REQ-018 Access takes effect at the clock edge where select=1 and rdy is not pulled low by this block; accesses during a stall are ignored.
REQ-019 Writes: idx0->ctrl, idx1->mask, idx5->scroll, idx6->addr, idx7->VRAM data; idx2/3/4 writes are ignored.
REQ-020 Reads: idx2 -> {vblank, spr0_hit, spr_ovf, 5'b0}; idx7 -> read buffer; all other indices read 8'h00.
REQ-021 Toggle w (1 bit) is shared by $2005 and $2006; reading idx2 clears w and vblank at that edge.
REQ-022 $2005 write: w=0 -> scroll_x=data, w=1; w=1 -> scroll_y=data, w=0.
REQ-023 $2006 write: w=0 -> t[13:8]=data[5:0], w=1; w=1 -> t[7:0]=data, v=t (new value), w=0; t and v are 14-bit.
REQ-024 vaddr = v at all times.
REQ-025 FSM states IDLE, BUSY; IDLE->BUSY on an idx7 access; BUSY->IDLE on the edge vack=1.
REQ-026 In BUSY: vreq=1, vwe=1 for write / 0 for read, vdout = written byte (latched at entry), rdy driven 0.
REQ-027 The idx7 access itself completes in its own cycle (no stall); a read returns the old buffer value that cycle.
REQ-028 On vack: read -> buffer=vdin; both directions -> v = v + (ctrl[2] ? 32 : 1), 14-bit wrap (3FFF+1 -> 0000).
REQ-029 vblank: set on vblank_set, cleared on vblank_clr or idx2 read; simultaneous set and idx2 read -> flag set, read returns vblank=0; set and clr together -> clr wins.
REQ-030 nmi = ctrl[7] & vblank, combinational from registered state.
REQ-031 Writing ctrl[7]=1 while vblank=1 raises nmi the following cycle.

Reset
REQ-032 n_reset low: ctrl, mask, scroll_x, scroll_y, t, v, buffer = 0; w=0; vblank=0; FSM=IDLE; vreq=0, vwe=0; rdy and data high-Z; nmi=0.
REQ-033 Reset asserted in BUSY aborts the transfer immediately; a vack arriving after reset release is ignored in IDLE.

Verification
REQ-034 Write $2006=21,$2006=08, write $2007=5A with vack after 3 cycles -> vreq/vwe high, vaddr=0x2108, vdout=5A, rdy low 3 cycles, then v=0x2109.
REQ-035 ctrl=04, v=0x2000, two reads of $2007 with vdin=11 then 22 -> first read returns 00, second returns 11, buffer=22, v=0x2040.
REQ-036 Write $2006=3F, read $2002, write $2006=10,$2006=00 -> w reset by read; t/v=0x1000.
REQ-037 ctrl=80, vblank_set pulse -> nmi=1 next cycle; read $3FFA (mirror of $2002) returns 80|status, nmi=0 after.
REQ-038 vblank_set coincident with $2002 read -> read returns bit7=0, vblank=1 afterwards.
REQ-039 n_reset low mid-BUSY -> vreq=0, rdy high-Z, all registers 0 within the reset cycle.
